// File: rtl/latch_bank.sv
// latch_bank: a bank of CHANNELS independent WIDTH-bit storage registers, each gated by
// its own enable bit, with a shared operating mode (hold, parallel load, shift-left,
// rotate-right). Per-channel sticky change flags and a saturating change counter expose
// activity to downstream status logic.
//
// Ports
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset
//   ctrl         per-channel enable, bit i gates channel i
//   mode         00 hold, 01 load, 10 shift-left, 11 rotate-right
//   d            parallel load data, channel i in d[i*WIDTH +: WIDTH]
//   ser_in       serial input shifted into the LSB in shift-left mode
//   clr_updated  clears the sticky updated flags (a same-cycle change still sets)
//   q            stored channel values, same packing as d
//   qn           bitwise complement of q
//   updated      per-channel sticky "value changed since last clear"
//   change_cnt   saturating count of channel value changes
module latch_bank #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       ctrl,
  input  logic [1:0]                mode,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic                      ser_in,
  input  logic                      clr_updated,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS*WIDTH-1:0] qn,
  output logic [CHANNELS-1:0]       updated,
  output logic [CNT_W-1:0]          change_cnt
);

  localparam logic [1:0] ModeHold  = 2'b00;
  localparam logic [1:0] ModeLoad  = 2'b01;
  localparam logic [1:0] ModeShftL = 2'b10;
  localparam logic [1:0] ModeRotR  = 2'b11;

  localparam logic [CNT_W:0] CntMax = {1'b0, {CNT_W{1'b1}}};

  logic [CHANNELS-1:0][WIDTH-1:0] val_q, val_d;
  logic [CHANNELS-1:0][WIDTH-1:0] d_ch;
  logic [CHANNELS-1:0]            upd_q, upd_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [CHANNELS-1:0]            chg;
  logic [CNT_W:0]                 chg_pop;
  logic [CNT_W:0]                 cnt_sum;

  assign d_ch = d;

  // Next value of one channel given its current value and parallel data.
  function automatic logic [WIDTH-1:0] next_value(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] din,
    input logic [1:0]       md,
    input logic             sin
  );
    logic [WIDTH-1:0] nv;
    nv = cur;
    unique case (md)
      ModeHold:  nv = cur;
      ModeLoad:  nv = din;
      ModeShftL: nv = {cur[WIDTH-2:0], sin};
      ModeRotR:  nv = {cur[0], cur[WIDTH-1:1]};
      default:   nv = cur;
    endcase
    return nv;
  endfunction

  always_comb begin
    val_d = val_q;
    chg   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (ctrl[i]) begin
        val_d[i] = next_value(val_q[i], d_ch[i], mode, ser_in);
      end
      // Writes that reproduce the current value do not count as changes.
      chg[i] = (val_d[i] != val_q[i]);
    end
  end

  // Set has priority over clear so a change in the clearing cycle is never lost.
  always_comb begin
    upd_d = chg | (upd_q & ~{CHANNELS{clr_updated}});
  end

  // Sum is formed one bit wider than the counter so overflow is visible before clamping.
  always_comb begin
    chg_pop = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      chg_pop = chg_pop + {{CNT_W{1'b0}}, chg[i]};
    end
    cnt_sum = {1'b0, cnt_q} + chg_pop;
    if (cnt_sum > CntMax) begin
      cnt_d = CntMax[CNT_W-1:0];
    end else begin
      cnt_d = cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
      upd_q <= '0;
      cnt_q <= '0;
    end else begin
      val_q <= val_d;
      upd_q <= upd_d;
      cnt_q <= cnt_d;
    end
  end

  assign q          = val_q;
  assign qn         = ~val_q;
  assign updated    = upd_q;
  assign change_cnt = cnt_q;

endmodule

// File: tb/tb_latch_bank.sv
// Self-checking bench for latch_bank: directed steps from the test plan followed by
// randomized cycles, all compared against an arithmetic reference model.
module tb_latch_bank;

  localparam int W  = 8;
  localparam int C  = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk;
  logic           rst_n;
  logic [C-1:0]   ctrl;
  logic [1:0]     mode;
  logic [C*W-1:0] d;
  logic           ser_in;
  logic           clr_updated;
  logic [C*W-1:0] q;
  logic [C*W-1:0] qn;
  logic [C-1:0]   updated;
  logic [CW-1:0]  change_cnt;

  int checks;
  int failures;

  // Reference model state.
  int m_val [C];
  int m_upd [C];
  int m_cnt;

  latch_bank #(
    .WIDTH   (W),
    .CHANNELS(C),
    .CNT_W   (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctrl       (ctrl),
    .mode       (mode),
    .d          (d),
    .ser_in     (ser_in),
    .clr_updated(clr_updated),
    .q          (q),
    .qn         (qn),
    .updated    (updated),
    .change_cnt (change_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_q();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < C; i++) v = v | (32'(m_val[i]) << (i * W));
    return v;
  endfunction

  function automatic logic [31:0] exp_upd();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < C; i++) if (m_upd[i] != 0) v = v | (32'd1 << i);
    return v;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_q"},   32'(q),          exp_q());
    check({tag, "_qn"},  32'(qn),         ~exp_q());
    check({tag, "_upd"}, 32'(updated),    exp_upd());
    check({tag, "_cnt"}, 32'(change_cnt), 32'(m_cnt));
  endtask

  task automatic model_reset();
    for (int i = 0; i < C; i++) begin
      m_val[i] = 0;
      m_upd[i] = 0;
    end
    m_cnt = 0;
  endtask

  // Applies the per-edge rules with plain integer arithmetic.
  task automatic model_step();
    int r, n, changes;
    changes = 0;
    for (int i = 0; i < C; i++) begin
      r = m_val[i];
      n = r;
      if (ctrl[i]) begin
        case (mode)
          2'd1: n = int'(d[i*W +: W]);
          2'd2: n = (r * 2 + int'(ser_in)) % (1 << W);
          2'd3: n = (r / 2) + (r % 2) * (1 << (W - 1));
          default: n = r;
        endcase
      end
      m_val[i] = n;
      if (n != r) begin
        changes++;
        m_upd[i] = 1;
      end else if (clr_updated) begin
        m_upd[i] = 0;
      end
    end
    m_cnt = (m_cnt + changes > CMAX) ? CMAX : m_cnt + changes;
  endtask

  // Called at posedge+1; drives inputs, takes one edge, checks at posedge+1.
  task automatic cycle(input logic [C-1:0] c, input logic [1:0] md, input logic [C*W-1:0] dv,
                       input logic s, input logic clr, input string tag);
    ctrl        = c;
    mode        = md;
    d           = dv;
    ser_in      = s;
    clr_updated = clr;
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
  endtask

  // Asynchronous reset between edges; inputs asking for a load must be ignored.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all({tag, "_async"});
    ctrl  = '1;
    mode  = 2'b01;
    d     = $urandom;
    @(posedge clk);
    #1;
    check_all({tag, "_held"});
    rst_n = 1'b1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    ctrl        = '0;
    mode        = 2'b00;
    d           = '0;
    ser_in      = 1'b0;
    clr_updated = 1'b0;
    model_reset();

    #2;
    check_all("init");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Mid-run reset after loading 0xA5 everywhere.
    cycle(4'hF, 2'b01, 32'hA5A5A5A5, 1'b0, 1'b0, "load_a5");
    check("load_a5_const", 32'(q), 32'hA5A5A5A5);
    do_reset("rst1");
    check("rst1_qn_const", 32'(qn), 32'hFFFFFFFF);

    // Gated load.
    cycle(4'b0101, 2'b01, 32'h44332211, 1'b0, 1'b0, "gl1");
    check("gl1_q_const", 32'(q), 32'h00330011);
    check("gl1_cnt_const", 32'(change_cnt), 32'd2);
    cycle(4'b0101, 2'b01, 32'h44332211, 1'b0, 1'b0, "gl2");
    check("gl2_cnt_const", 32'(change_cnt), 32'd2);

    // Shift and rotate on channel 0.
    cycle(4'b0001, 2'b01, 32'h00000081, 1'b0, 1'b0, "ld81");
    cycle(4'b0001, 2'b10, 32'h0, 1'b1, 1'b0, "shl");
    check("shl_ch0_const", 32'(q[7:0]), 32'h03);
    cycle(4'b0001, 2'b11, 32'h0, 1'b0, 1'b0, "rotr");
    check("rotr_ch0_const", 32'(q[7:0]), 32'h81);
    for (int k = 0; k < 3; k++) cycle(4'hF, 2'b00, 32'hDEADBEEF, 1'b1, 1'b0, "hold");
    check("hold_cnt_const", 32'(change_cnt), 32'd5);

    // Sticky flags: clear alone, then set-beats-clear.
    cycle(4'h0, 2'b00, 32'h0, 1'b0, 1'b1, "clr1");
    check("clr1_upd_const", 32'(updated), 32'd0);
    cycle(4'b0001, 2'b01, 32'h00000055, 1'b0, 1'b0, "set0");
    check("set0_upd_const", 32'(updated), 32'b0001);
    cycle(4'h0, 2'b00, 32'h0, 1'b0, 1'b1, "clr2");
    cycle(4'b0001, 2'b01, 32'h000000AA, 1'b0, 1'b1, "setclr");
    check("setclr_upd_const", 32'(updated), 32'b0001);

    // Saturation of the change counter.
    do_reset("rst2");
    cycle(4'hF, 2'b01, 32'hFFFFFFFF, 1'b0, 1'b0, "sat1");
    cycle(4'hF, 2'b01, 32'h00000000, 1'b0, 1'b0, "sat2");
    cycle(4'hF, 2'b01, 32'hFFFFFFFF, 1'b0, 1'b0, "sat3");
    check("sat3_cnt_const", 32'(change_cnt), 32'd12);
    cycle(4'hF, 2'b01, 32'h00000000, 1'b0, 1'b0, "sat4");
    check("sat4_cnt_const", 32'(change_cnt), 32'd15);
    cycle(4'hF, 2'b01, 32'hFFFFFFFF, 1'b0, 1'b0, "sat5");
    check("sat5_cnt_const", 32'(change_cnt), 32'd15);
    cycle(4'h0, 2'b00, 32'h0, 1'b0, 1'b1, "sat_clr");
    check("sat_clr_cnt_const", 32'(change_cnt), 32'd15);

    // Writes that leave values unchanged.
    do_reset("rst3");
    cycle(4'b0001, 2'b01, 32'h000000FF, 1'b0, 1'b0, "ldff");
    cycle(4'h0, 2'b00, 32'h0, 1'b0, 1'b1, "nc_clr");
    cycle(4'hF, 2'b11, 32'h0, 1'b0, 1'b0, "nc_rot");
    cycle(4'b1110, 2'b10, 32'h0, 1'b0, 1'b0, "nc_shl");
    check("nc_q_const", 32'(q), 32'h000000FF);
    check("nc_cnt_const", 32'(change_cnt), 32'd1);
    check("nc_upd_const", 32'(updated), 32'd0);

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 40) == 0) begin
        do_reset("rnd_rst");
      end else begin
        cycle(C'($urandom), 2'($urandom), $urandom, 1'($urandom), ($urandom_range(0, 5) == 0),
              "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/latch_bank.md
# latch_bank

Parametrised, clocked successor to the single-bit D latch: a bank of CHANNELS independent WIDTH-bit storage registers, each gated by its own control (enable) bit. A shared mode selects hold, parallel load, serial shift-left or rotate-right. Per-channel sticky change flags and a saturating change counter report activity to downstream status logic. The block sits between the datapath and status/CSR logic wherever grouped, gated capture of multi-bit values is needed.

## Interface
- WIDTH, 8, bits per channel (≥2)
- CHANNELS, 4, number of channels (≥1)
- CNT_W, 16, width of the change counter (≥ bits needed to hold CHANNELS)

- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- ctrl  input  CHANNELS  per-channel enable; bit i gates channel i
- mode  input  2  00 HOLD, 01 LOAD, 10 SHIFT_L, 11 ROT_R
- d  input  CHANNELS*WIDTH  parallel data; channel i is d[i*WIDTH +: WIDTH]
- ser_in  input  1  serial input for SHIFT_L (shared by all channels)
- clr_updated  input  1  clears all updated flags
- q  output  CHANNELS*WIDTH  stored values, same packing as d
- qn  output  CHANNELS*WIDTH  bitwise complement of q
- updated  output  CHANNELS  sticky flag: channel value changed since last clear
- change_cnt  output  CNT_W  saturating count of channel value changes

## Operation
- Reset (rst_n low, asynchronous, takes effect immediately, including mid-operation): q = 0, qn = all ones, updated = 0, change_cnt = 0. All inputs are ignored while rst_n is low.
- Per channel i, on each rising edge with rst_n high, let r = current value and nxt = next value:
  - ctrl[i] = 0: nxt = r, for every mode.
  - mode HOLD: nxt = r, regardless of ctrl.
  - mode LOAD: nxt = d slice i.
  - mode SHIFT_L: nxt = {r[WIDTH-2:0], ser_in}; the MSB is discarded.
  - mode ROT_R: nxt = {r[0], r[WIDTH-1:1]}.
- chg[i] = (nxt != r). Writes that leave the value unchanged are not changes. This covers loading an identical value, shifting 0 into all-zero, and rotating all-ones.
- updated[i] next = chg[i] | (updated[i] & ~clr_updated). If a set and a clear occur in the same cycle, the set wins.
- change_cnt next = min(change_cnt + popcount(chg), 2^CNT_W − 1). The counter saturates and never wraps. The addition is performed CNT_W+1 bits wide before clamping.
- Channels are fully independent; there is no cross-channel data movement.
- qn is a pure combinational complement of the q registers, with no extra state.

## Timing
- Latency: q, updated and change_cnt reflect an edge's inputs immediately after that edge (1-cycle registered). qn follows q in the same cycle.
- No handshake is used. ctrl, mode, d, ser_in and clr_updated are sampled only at rising edges and must be stable per normal setup/hold.
- Reset release: the first state update occurs on the first rising edge after rst_n goes high.
- Changing mode or ctrl between edges has no effect until the next edge; nothing is level-transparent.
- The counter reaching 2^CNT_W − 1 stays there until reset; clr_updated does not clear change_cnt.

## Test plan
(WIDTH=8, CHANNELS=4, CNT_W=4 unless noted)
- Reset: drive rst_n=0 mid-run after loading 0xA5 into all channels -> q=0, qn=0xFFFFFFFF, updated=0, change_cnt=0 immediately, with no clock edge needed.
- Gated load: mode=LOAD, ctrl=4'b0101, d=0x44332211 -> after one edge q=0x00330011, updated=4'b0101, change_cnt=2. Repeat the same cycle -> no change, change_cnt stays 2.
- Shift/rotate: from ch0=0x81, ctrl=4'b0001. Apply SHIFT_L with ser_in=1 -> ch0=0x03. Then ROT_R -> ch0=0x81. Then HOLD with ctrl=4'hF for 3 cycles -> ch0 stays 0x81 and change_cnt does not increment.
- Sticky flags: set updated=4'b0001, then pulse clr_updated alone -> 0. Next, clr_updated=1 in the same cycle as a ch0 load of a new value -> updated[0]=1 (set wins).
- Saturation: repeated LOAD with ctrl=4'hF, alternating d=0x00000000 / 0xFFFFFFFF -> change_cnt goes 4, 8, 12, 15, 15 (clamped, no wrap).
- No-change writes: ROT_R on 0xFF and SHIFT_L with ser_in=0 on 0x00 -> values unchanged, updated and change_cnt unchanged.
